// File: rtl/red_pitaya_haze_gain_ramp_pkg.sv
// Shared definitions for the haze gain ramp: register map, FSM states,
// and ctrl register bit positions.
package haze_pkg;

    localparam logic [15:0] ADDR_TGT_KP   = 16'h0100;
    localparam logic [15:0] ADDR_TGT_KP2  = 16'h0104;
    localparam logic [15:0] ADDR_KP       = 16'h0108;
    localparam logic [15:0] ADDR_KP2      = 16'h010C;
    localparam logic [15:0] ADDR_STEP     = 16'h0110;
    localparam logic [15:0] ADDR_INTERVAL = 16'h0114;
    localparam logic [15:0] ADDR_CTRL     = 16'h0118;
    localparam logic [15:0] ADDR_STATUS   = 16'h011C;
    localparam logic [15:0] ADDR_GAINBITS = 16'h020C;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/red_pitaya_haze_gain_ramp_if.sv
// PS register bus bundle for the haze gain ramp.
// Ports: addr/wen/ren/wdata from master, ack/rdata from slave.
interface red_pitaya_haze_gain_ramp_if;

    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] wdata;

    modport master (
        output addr, wen, ren, wdata,
        input  ack, rdata
    );

    modport slave (
        input  addr, wen, ren, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/red_pitaya_haze_gain_ramp_step.sv
// One-channel rate-limited step: moves cur toward tgt by at most step,
// never overshooting. Ports: cur, tgt, step in; nxt out (combinational).
module haze_ramp_step #(
    parameter int GAINBITS = 24
) (
    input  logic [GAINBITS-1:0] cur,
    input  logic [GAINBITS-1:0] tgt,
    input  logic [GAINBITS-2:0] step,
    output logic [GAINBITS-1:0] nxt
);

    logic [GAINBITS:0]   diff;
    logic [GAINBITS:0]   mag;
    logic [GAINBITS:0]   step_w;
    logic [GAINBITS-1:0] step_g;

    always_comb begin
        // One extra bit so tgt - cur cannot wrap for any signed pair.
        diff   = {tgt[GAINBITS-1], tgt} - {cur[GAINBITS-1], cur};
        mag    = diff[GAINBITS] ? (~diff + 1'b1) : diff;
        step_w = {2'b00, step};
        step_g = {1'b0, step};
        nxt    = cur;
        if (step == '0 || mag <= step_w) begin
            nxt = tgt;
        end else if (diff[GAINBITS]) begin
            nxt = cur - step_g;
        end else begin
            nxt = cur + step_g;
        end
    end

endmodule

// File: rtl/red_pitaya_haze_gain_ramp.sv
// Rate-limited sequencer for the haze kp/kp2 gain words, with PS bus regs.
// Ports: clk_i, rst_i, bus (slave), kp_o, kp2_o, busy_o, done_o.
module red_pitaya_haze_gain_ramp
    import haze_pkg::*;
#(
    parameter int GAINBITS = 24,
    parameter int CNTBITS  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    red_pitaya_haze_gain_ramp_if.slave   bus,
    output logic [GAINBITS-1:0]          kp_o,
    output logic [GAINBITS-1:0]          kp2_o,
    output logic                         busy_o,
    output logic                         done_o
);

    state_t              state;
    state_t              state_nxt;
    logic [GAINBITS-1:0] tgt_kp;
    logic [GAINBITS-1:0] tgt_kp2;
    logic [GAINBITS-2:0] step;
    logic [CNTBITS-1:0]  interval;
    logic [CNTBITS-1:0]  cnt;
    logic [GAINBITS-1:0] kp_nxt;
    logic [GAINBITS-1:0] kp2_nxt;
    logic                sticky;
    logic                done_q;
    logic                ctrl_wr;
    logic                start_req;
    logic                abort_req;
    logic                step_edge;
    logic                finish;

    haze_ramp_step #(.GAINBITS(GAINBITS)) u_step_kp (
        .cur  (kp_o),
        .tgt  (tgt_kp),
        .step (step),
        .nxt  (kp_nxt)
    );

    haze_ramp_step #(.GAINBITS(GAINBITS)) u_step_kp2 (
        .cur  (kp2_o),
        .tgt  (tgt_kp2),
        .step (step),
        .nxt  (kp2_nxt)
    );

    // Abort dominates start when both bits arrive in one write.
    always_comb begin
        ctrl_wr   = bus.wen && (bus.addr == ADDR_CTRL);
        abort_req = ctrl_wr && bus.wdata[CTRL_ABORT];
        start_req = ctrl_wr && bus.wdata[CTRL_START]
                    && !bus.wdata[CTRL_ABORT];
        // A start during RAMP only reloads the counter for that edge.
        step_edge = (state == RAMP) && (cnt == '0)
                    && !abort_req && !start_req;
        finish    = step_edge && (kp_nxt == tgt_kp)
                    && (kp2_nxt == tgt_kp2);
    end

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_req) state_nxt = RAMP;
            RAMP: if (abort_req || finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o = (state == RAMP);
        done_o = done_q;
    end

    // Interval counter and gain outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            kp_o   <= '0;
            kp2_o  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (start_req) begin
                cnt <= interval;
            end else if (state == RAMP && !abort_req) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt <= interval;
                end
            end
            if (step_edge) begin
                kp_o  <= kp_nxt;
                kp2_o <= kp2_nxt;
            end
        end
    end

    // Bus-writable registers and sticky done
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgt_kp   <= '0;
            tgt_kp2  <= '0;
            step     <= '0;
            interval <= '0;
            sticky   <= 1'b0;
        end else begin
            if (bus.wen) begin
                case (bus.addr)
                    ADDR_TGT_KP:   tgt_kp   <= bus.wdata[GAINBITS-1:0];
                    ADDR_TGT_KP2:  tgt_kp2  <= bus.wdata[GAINBITS-1:0];
                    ADDR_STEP:     step     <= bus.wdata[GAINBITS-2:0];
                    ADDR_INTERVAL: interval <= bus.wdata[CNTBITS-1:0];
                    default: ;
                endcase
            end
            if (finish) begin
                sticky <= 1'b1;
            end else if (start_req && state == IDLE) begin
                sticky <= 1'b0;
            end else if (bus.ren && bus.addr == ADDR_STATUS) begin
                sticky <= 1'b0;
            end
        end
    end

    // Read path: one-cycle latency, unmapped addresses read as zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= bus.wen | bus.ren;
            case (bus.addr)
                ADDR_TGT_KP:
                    bus.rdata <= {{(32-GAINBITS){1'b0}}, tgt_kp};
                ADDR_TGT_KP2:
                    bus.rdata <= {{(32-GAINBITS){1'b0}}, tgt_kp2};
                ADDR_KP:
                    bus.rdata <= {{(32-GAINBITS){1'b0}}, kp_o};
                ADDR_KP2:
                    bus.rdata <= {{(32-GAINBITS){1'b0}}, kp2_o};
                ADDR_STEP:
                    bus.rdata <= {{(33-GAINBITS){1'b0}}, step};
                ADDR_INTERVAL:
                    bus.rdata <= {{(32-CNTBITS){1'b0}}, interval};
                ADDR_STATUS:
                    bus.rdata <= {30'd0, sticky, busy_o};
                ADDR_GAINBITS:
                    bus.rdata <= 32'(GAINBITS);
                default:
                    bus.rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_red_pitaya_haze_gain_ramp.sv
// Directed bench for red_pitaya_haze_gain_ramp: register table plus
// hand-timed ramp, abort, reset, jump and clamp sequences.
module tb_red_pitaya_haze_gain_ramp;

    logic        clk;
    logic        rst_i;
    logic [23:0] kp_o;
    logic [23:0] kp2_o;
    logic        busy_o;
    logic        done_o;

    int checks;
    int failures;

    red_pitaya_haze_gain_ramp_if bif ();

    red_pitaya_haze_gain_ramp #(
        .GAINBITS (24),
        .CNTBITS  (16)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .bus    (bif.slave),
        .kp_o   (kp_o),
        .kp2_o  (kp2_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] g(input int v);
        logic [31:0] t;
        t = v;
        return {8'h00, t[23:0]};
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bif.addr  = a;
        bif.wdata = d;
        bif.wen   = 1'b1;
        @(negedge clk);
        bif.wen   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a,
                              input logic [31:0] exp);
        @(negedge clk);
        bif.addr = a;
        bif.ren  = 1'b1;
        @(negedge clk);
        bif.ren  = 1'b0;
        check({name, "_ack"}, {31'd0, bif.ack}, 32'd1);
        check(name, bif.rdata, exp);
    endtask

    int exp3[4];
    bit seen_done;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_i     = 1'b1;
        bif.addr  = '0;
        bif.wdata = '0;
        bif.wen   = 1'b0;
        bif.ren   = 1'b0;

        tbl[0]  = '{1'b1, 16'h0100, 32'd1000, 32'd0};
        tbl[1]  = '{1'b0, 16'h0100, 32'd0, 32'd1000};
        tbl[2]  = '{1'b1, 16'h0104, 32'hFFFFFC18, 32'd0};
        tbl[3]  = '{1'b0, 16'h0104, 32'd0, 32'h00FFFC18};
        tbl[4]  = '{1'b1, 16'h0110, 32'd300, 32'd0};
        tbl[5]  = '{1'b0, 16'h0110, 32'd0, 32'd300};
        tbl[6]  = '{1'b1, 16'h0114, 32'd3, 32'd0};
        tbl[7]  = '{1'b0, 16'h0114, 32'd0, 32'd3};
        tbl[8]  = '{1'b0, 16'h0118, 32'd0, 32'd0};
        tbl[9]  = '{1'b0, 16'h020C, 32'd0, 32'd24};
        tbl[10] = '{1'b0, 16'h0300, 32'd0, 32'd0};
        tbl[11] = '{1'b0, 16'h011C, 32'd0, 32'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_kp", g(kp_o), 32'd0);
        check("rst_kp2", g(kp2_o), 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ack", {31'd0, bif.ack}, 32'd0);
        check("rst_rdata", bif.rdata, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].we) begin
                bus_write(tbl[i].a, tbl[i].d);
            end else begin
                read_check($sformatf("reg%0d", i), tbl[i].a, tbl[i].exp);
            end
        end

        // Ramp 0 -> +/-1000, step 300, interval 3
        bus_write(16'h0118, 32'h1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k % 4 == 0) begin
                check($sformatf("ramp_kp_e%0d", k), g(kp_o),
                      g(k == 16 ? 1000 : 75 * k));
                check($sformatf("ramp_kp2_e%0d", k), g(kp2_o),
                      g(k == 16 ? -1000 : -75 * k));
            end
            if (k >= 15) begin
                check($sformatf("ramp_done_e%0d", k), {31'd0, done_o},
                      {31'd0, (k == 16)});
            end
        end
        check("ramp_busy_end", {31'd0, busy_o}, 32'd0);
        read_check("status_sticky", 16'h011C, 32'h2);
        read_check("status_clr", 16'h011C, 32'h0);

        // Reset in the middle of a ramp back toward zero
        bus_write(16'h0100, 32'd0);
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0118, 32'h1);
        repeat (6) @(posedge clk);
        read_check("mid_kp_read", 16'h0108, 32'd700);
        rst_i = 1'b1;
        #1;
        check("arst_kp", g(kp_o), 32'd0);
        check("arst_kp2", g(kp2_o), 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_ack", {31'd0, bif.ack}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        read_check("arst_tgt", 16'h0100, 32'd0);

        // Abort after two steps
        bus_write(16'h0100, 32'd1000);
        bus_write(16'h0104, 32'hFFFFFC18);
        bus_write(16'h0110, 32'd300);
        bus_write(16'h0114, 32'd3);
        bus_write(16'h0118, 32'h1);
        repeat (8) @(posedge clk);
        bus_write(16'h0118, 32'h3);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_kp", g(kp_o), 32'd600);
        check("abort_kp2", g(kp2_o), g(-600));
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        check("abort_kp_hold", g(kp_o), 32'd600);
        read_check("abort_status", 16'h011C, 32'h0);

        // step=0 single jump
        bus_write(16'h0110, 32'd0);
        bus_write(16'h0114, 32'd5);
        bus_write(16'h0100, 32'h1234);
        bus_write(16'h0104, g(-600));
        bus_write(16'h0118, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) check("jump_kp_e5", g(kp_o), 32'd600);
            if (k == 6) check("jump_kp_e6", g(kp_o), 32'h1234);
            if (k >= 5) begin
                check($sformatf("jump_done_e%0d", k), {31'd0, done_o},
                      {31'd0, (k == 6)});
            end
        end

        // Clamp near full scale without wrap
        bus_write(16'h0114, 32'd0);
        bus_write(16'h0100, 32'h007FFFF0);
        bus_write(16'h0118, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("clamp_start_kp", g(kp_o), 32'h7FFFF0);
        check("clamp_start_busy", {31'd0, busy_o}, 32'd0);
        exp3[0] = 32'h3FFFF1;
        exp3[1] = 32'hFFFFF2;
        exp3[2] = 32'hBFFFF3;
        exp3[3] = 32'h800000;
        bus_write(16'h0100, 32'hFF800000);
        bus_write(16'h0110, 32'h003FFFFF);
        bus_write(16'h0118, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("clamp_kp_e%0d", k), g(kp_o), g(exp3[k-1]));
            check($sformatf("clamp_done_e%0d", k), {31'd0, done_o},
                  {31'd0, (k == 4)});
        end
        @(posedge clk);
        #1;
        check("clamp_kp_final", g(kp_o), 32'h800000);
        check("clamp_busy_end", {31'd0, busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
